// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the two-input gate truth-table checker.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden gate: expected output for the selected operation.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       exp
);

  always_comb begin
    exp = 1'b0;
    case (op)
      OP_AND:  exp = a & b;
      OP_OR:   exp = a | b;
      OP_XOR:  exp = a ^ b;
      OP_NAND: exp = ~(a & b);
      default: exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps all four {a,b} vectors into a gate under test and scores its output
// against the reference gate selected by EXP_OP.
module gate_tt_checker
  import gate_chk_pkg::*;
#(
  parameter logic [1:0]  EXP_OP = 2'd1,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail_vec
);

  localparam logic [SETTLE_W-1:0] SETTLE_M1 = SETTLE_W'(SETTLE - 1);

  state_t              state, state_nx;
  logic [1:0]          idx;
  logic [SETTLE_W-1:0] cnt;
  logic                exp_val;
  logic                mismatch;

  gate_ref_model u_ref (
    .op  (EXP_OP),
    .a   (a),
    .b   (b),
    .exp (exp_val)
  );

  // Case inequality so an X/Z gate output is scored as a failure.
  assign mismatch = (dut_out !== exp_val);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = DRIVE;
      DRIVE:      state_nx = WAIT;
      WAIT:       if (cnt == '0) state_nx = SAMPLE;
      SAMPLE:     state_nx = (idx == 2'd3) ? DONE : DRIVE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      cnt            <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx            <= '0;
            a              <= 1'b0;
            b              <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        DRIVE: cnt <= SETTLE_M1;
        WAIT:  if (cnt != '0) cnt <= cnt - 1'b1;
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 3'd1;
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_vec <= {a, b};
            end
          end
          // The next vector is loaded here so it is already on a/b in DRIVE.
          if (idx != 2'd3) begin
            idx <= idx + 2'd1;
            a   <= idx[1] | idx[0];
            b   <= ~idx[0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == DRIVE) || (state == WAIT) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 The block SHALL have parameter EXP_OP, default 2'd1, selecting the expected function: 0=AND, 1=OR, 2=XOR, 3=NAND.
REQ-002 The block SHALL have parameter SETTLE, default 1, giving the number of wait cycles between driving a vector and sampling it; legal range 1..15.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, width 1: level-sampled request to run a full truth-table sweep.
REQ-006 The block SHALL have port a, output, width 1: registered stimulus to DUT input a.
REQ-007 The block SHALL have port b, output, width 1: registered stimulus to DUT input b.
REQ-008 The block SHALL have port dut_out, input, width 1: DUT gate output under test.
REQ-009 The block SHALL have port busy, output, width 1: high while a sweep is in progress.
REQ-010 The block SHALL have port done, output, width 1: high once a sweep has completed; held until the next accepted start or reset.
REQ-011 The block SHALL have port pass, output, width 1: high only when done=1 and err_count=0.
REQ-012 The block SHALL have port err_count, output, width 3: number of mismatching vectors, 0..4.
REQ-013 The block SHALL have port fail_valid, output, width 1: high once at least one mismatch has been recorded in the current sweep.
REQ-014 The block SHALL have port first_fail_vec, output, width 2: {a,b} of the first mismatching vector; meaningful only while fail_valid=1.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, WAIT, SAMPLE and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL cause the next edge to:
  - enter DRIVE with vector index 0;
  - clear err_count, fail_valid, first_fail_vec and done.
REQ-017 On entry to DRIVE, a and b SHALL be loaded with index[1] and index[0] respectively; a and b SHALL be held stable through WAIT and SAMPLE.
REQ-018 DRIVE SHALL last 1 cycle, then go to WAIT.
REQ-019 WAIT SHALL last exactly SETTLE cycles, counted by a 4-bit down-counter, then go to SAMPLE.
REQ-020 SAMPLE SHALL last 1 cycle; at its closing edge dut_out SHALL be compared with the expected value for EXP_OP.
REQ-021 X or Z on dut_out SHALL count as a mismatch (case-inequality comparison).
REQ-022 On a mismatch, err_count SHALL increment by 1; on the first mismatch of the sweep, fail_valid and first_fail_vec SHALL also be set.
REQ-023 After SAMPLE, an index below 3 SHALL increment the index and return to DRIVE; index 3 SHALL go to DONE without wrapping.
REQ-024 Vector order SHALL be 00, 01, 10, 11.
REQ-025 If start is accepted at edge k, done SHALL rise at edge k+4*(SETTLE+2), which is k+12 with the default SETTLE.
REQ-026 busy SHALL be 1 in DRIVE, WAIT and SAMPLE, and 0 otherwise.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 In DONE, a and b SHALL hold the last vector (11) until the next sweep starts.
REQ-029 err_count SHALL never exceed 4, so no saturation logic is required.

Reset
REQ-030 While rst=1 at a clock edge, the next state SHALL be:
  - state IDLE, index 0, a=0, b=0;
  - busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=2'b00.
REQ-031 rst SHALL take priority over start and over any in-flight sweep; a reset mid-sweep SHALL abandon the sweep, and no partial results SHALL be kept.

Structure
REQ-032 A shared package gate_chk_pkg SHALL hold:
  - the FSM state typedef;
  - the EXP_OP code constants;
  - the SETTLE width constant.
REQ-033 Expected-value generation SHALL be a combinational sub-module gate_ref_model (inputs op, a, b; output exp), instantiated once.

Verification
REQ-034 Correct OR DUT, EXP_OP=1, start pulsed at edge k -> done=1 at k+12, pass=1, err_count=0, fail_valid=0.
REQ-035 DUT computing a&b, EXP_OP=1 -> err_count=2, first_fail_vec=01, fail_valid=1, pass=0.
REQ-036 dut_out tied 0, EXP_OP=1 -> err_count=3, first_fail_vec=01; dut_out tied X -> err_count=4, first_fail_vec=00.
REQ-037 AND DUT with EXP_OP=0, and XOR DUT with EXP_OP=2 -> pass=1 in both cases; SETTLE=3 -> done at k+20.
REQ-038 start re-pulsed at cycle 5 of a sweep -> no effect, and done still rises at k+12; rst during vector 10 -> next cycle IDLE with a=b=0 and err_count=0, and a fresh start completes normally.
